// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_ctrl
//  Description : Multiplexed common-anode 7-segment display scanner with
//                frame-coherent snapshot, decimal points, blink, leading-zero
//                blanking, 8-level PWM brightness and optional hex glyphs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_HZ   = 2,
  parameter int HEX_EN     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dot_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic [2:0]              brightness,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [7:0]              fnd_data,
  output logic                    frame_tick
);

  localparam int SCAN_DIV      = CLK_HZ / SCAN_HZ;
  localparam int SUB_DIV       = SCAN_DIV / 8;
  localparam int BLINK_DIV_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_DIV     = (BLINK_DIV_RAW < 2) ? 2 : BLINK_DIV_RAW;
  localparam int SLOT_W        = $clog2(SCAN_DIV);
  localparam int IDX_W         = $clog2(NUM_DIGITS);
  localparam int BLINK_W       = $clog2(BLINK_DIV);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_phase;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dot;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lz;
  logic [2:0]              snap_bright;

  logic [NUM_DIGITS-1:0]   lz_blanked;
  logic [2:0]              sub_phase;
  logic [3:0]              cur_code;
  logic                    cur_dot;
  logic                    cur_blink;
  logic                    cur_lzb;
  logic                    show_seg;
  logic                    show_dp;
  logic [NUM_DIGITS-1:0]   next_com;
  logic [7:0]              next_data;

  // Segment pattern for one digit code, active low {dp,g,f,e,d,c,b,a}; dp off.
  function automatic logic [7:0] glyph(input logic [3:0] code);
    logic [7:0] g;
    case (code)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      4'd10:   g = (HEX_EN != 0) ? 8'h88 : 8'hFF;
      4'd11:   g = (HEX_EN != 0) ? 8'h83 : 8'hFF;
      4'd12:   g = (HEX_EN != 0) ? 8'hC6 : 8'hFF;
      4'd13:   g = (HEX_EN != 0) ? 8'hA1 : 8'hFF;
      4'd14:   g = (HEX_EN != 0) ? 8'h86 : 8'hFF;
      default: g = (HEX_EN != 0) ? 8'h8E : 8'hFF;
    endcase
    return g;
  endfunction

  // Slot / digit / blink timebase and the per-frame input snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dot    <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        if (digit_idx == IDX_LAST) begin
          digit_idx   <= '0;
          snap_digits <= digits;
          snap_dot    <= dot_en;
          snap_blink  <= blink_mask;
          snap_lz     <= lz_blank;
          snap_bright <= brightness;
          frame_tick  <= 1'b1;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero;
  // the rightmost digit always stays visible so a plain "0" still shows.
  always_comb begin
    logic above_zero;
    above_zero = 1'b1;
    lz_blanked = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above_zero    = above_zero && (snap_digits[4*i +: 4] == 4'd0);
      lz_blanked[i] = snap_lz && (i != 0) && above_zero;
    end
  end

  // Decode of the digit currently being scanned into next-cycle pin values.
  always_comb begin
    sub_phase = 3'(int'(slot_cnt) / SUB_DIV);
    cur_code  = 4'd0;
    cur_dot   = 1'b0;
    cur_blink = 1'b0;
    cur_lzb   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == digit_idx) begin
        cur_code  = snap_digits[4*i +: 4];
        cur_dot   = snap_dot[i];
        cur_blink = snap_blink[i];
        cur_lzb   = lz_blanked[i];
      end
    end

    // PWM gating and blink-off both fully darken the slot, dp included.
    show_seg = (sub_phase <= snap_bright) && !(cur_blink && blink_phase) && !cur_lzb;
    show_dp  = (sub_phase <= snap_bright) && !(cur_blink && blink_phase) && cur_dot;

    next_data = show_seg ? glyph(cur_code) : 8'hFF;
    if (show_dp) begin
      next_data[7] = 1'b0;
    end

    next_com = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) == digit_idx) && (show_seg || show_dp)) begin
        next_com[i] = 1'b0;
      end
    end
  end

  // Registered pin stage: common and segment lines change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fnd_com  <= '1;
      fnd_data <= 8'hFF;
    end else begin
      fnd_com  <= next_com;
      fnd_data <= next_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fnd_scan_ctrl
//  Description : Self-checking bench for fnd_scan_ctrl (hex and non-hex
//                builds driven in parallel) using an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dot_en;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic [2:0]  brightness;
  logic [3:0]  com_h;
  logic [7:0]  data_h;
  logic        tick_h;
  logic [3:0]  com_n;
  logic [7:0]  data_n;
  logic        tick_n;

  typedef struct {
    logic [3:0] com;
    logic [7:0] data;
    logic [3:0] com_nh;
    logic [7:0] data_nh;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  logic [7:0] glyph_tbl [16];

  fnd_scan_ctrl #(
    .CLK_HZ(800), .SCAN_HZ(100), .NUM_DIGITS(4), .BLINK_HZ(25), .HEX_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .digits(digits), .dot_en(dot_en),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .brightness(brightness),
    .fnd_com(com_h), .fnd_data(data_h), .frame_tick(tick_h)
  );

  fnd_scan_ctrl #(
    .CLK_HZ(800), .SCAN_HZ(100), .NUM_DIGITS(4), .BLINK_HZ(25), .HEX_EN(0)
  ) dut_nohex (
    .clk(clk), .reset(reset), .digits(digits), .dot_en(dot_en),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .brightness(brightness),
    .fnd_com(com_n), .fnd_data(data_n), .frame_tick(tick_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected pins for digit i at sub-phase s of a frame. With these sim
  // parameters the blink phase is 1 exactly in the second half of each frame.
  task automatic model(input int i, input int s, input logic [15:0] d,
                       input logic [3:0] dot, input logic [3:0] blk,
                       input logic lz, input logic [2:0] br, input bit hex,
                       output logic [3:0] com, output logic [7:0] data);
    logic [3:0] code;
    logic [7:0] g;
    bit phase, lit, blanked, seg, dp;
    code    = d[4*i +: 4];
    phase   = ((i * 8 + s) >= 16);
    lit     = (s <= int'(br)) && !(blk[i] && phase);
    blanked = lz && (i > 0) && ((d >> (4 * i)) == 16'd0);
    seg     = lit && !blanked;
    dp      = lit && dot[i];
    g       = (code < 4'd10 || hex) ? glyph_tbl[code] : 8'hFF;
    data    = seg ? g : 8'hFF;
    if (dp) data[7] = 1'b0;
    com     = (seg || dp) ? ~(4'b0001 << i) : 4'hF;
  endtask

  task automatic push_frame(input logic [15:0] d, input logic [3:0] dot,
                            input logic [3:0] blk, input logic lz,
                            input logic [2:0] br);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 8; s++) begin
        model(i, s, d, dot, blk, lz, br, 1'b1, e.com, e.data);
        model(i, s, d, dot, blk, lz, br, 1'b0, e.com_nh, e.data_nh);
        e.tick = (i == 3) && (s == 7);
        sb.push_back(e);
      end
    end
  endtask

  // Pops one frame of expectations; optionally changes digits mid-frame.
  task automatic check_frame(input string tag, input bit mid_en, input logic [15:0] mid_d);
    exp_t e;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (mid_en && c == 15) digits = mid_d;
      e = sb.pop_front();
      chk({tag, "_com"},  {4'h0, com_h},  {4'h0, e.com});
      chk({tag, "_data"}, data_h,         e.data);
      chk({tag, "_comn"}, {4'h0, com_n},  {4'h0, e.com_nh});
      chk({tag, "_datn"}, data_n,         e.data_nh);
      chk({tag, "_tick"}, {7'h0, tick_h}, {7'h0, e.tick});
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!tick_h && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick_seen"}, {7'h0, tick_h}, 8'h01);
  endtask

  task automatic run_case(input string tag, input logic [15:0] d, input logic [3:0] dot,
                          input logic [3:0] blk, input logic lz, input logic [2:0] br);
    digits = d; dot_en = dot; blink_mask = blk; lz_blank = lz; brightness = br;
    wait_tick(tag);
    push_frame(d, dot, blk, lz, br);
    check_frame(tag, 1'b0, 16'h0);
  endtask

  task automatic count_to_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_h && n < 100);
    chk({tag, "_tick_cycle"}, 8'(n), 8'd32);
  endtask

  // Directed sequence.
  initial begin
    glyph_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    digits = 16'h0; dot_en = 4'h0; blink_mask = 4'h0; lz_blank = 1'b0; brightness = 3'd0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_com",  {4'h0, com_h}, 8'h0F);
      chk("rst_data", data_h, 8'hFF);
      chk("rst_tick", {7'h0, tick_h}, 8'h00);
    end

    reset = 1'b0;
    digits = 16'h1234;
    brightness = 3'd7;
    count_to_tick("t1");
    push_frame(16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    check_frame("t1", 1'b0, 16'h0);

    push_frame(16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    check_frame("t2_old", 1'b1, 16'h5678);
    push_frame(16'h5678, 4'h0, 4'h0, 1'b0, 3'd7);
    check_frame("t2_new", 1'b0, 16'h0);

    run_case("t3_lz1",  16'h0007, 4'h0, 4'h0, 1'b1, 3'd7);
    run_case("t3_lz0",  16'h0007, 4'h0, 4'h0, 1'b0, 3'd7);
    run_case("t3_lzdp", 16'h0007, 4'b0100, 4'h0, 1'b1, 3'd7);
    run_case("t3_zero", 16'h0000, 4'h0, 4'h0, 1'b1, 3'd7);
    run_case("t4_br2",  16'h1234, 4'h0, 4'h0, 1'b0, 3'd2);
    run_case("t4_br0",  16'h1234, 4'h0, 4'h0, 1'b0, 3'd0);
    run_case("t5_bd",   16'h1234, 4'b0100, 4'b0010, 1'b0, 3'd7);
    run_case("t5_bd2",  16'h1234, 4'b0100, 4'b1100, 1'b0, 3'd7);
    run_case("t6_hex",  16'hABCD, 4'h0, 4'h0, 1'b0, 3'd7);
    run_case("t6_hexEF", 16'h90EF, 4'b0001, 4'h0, 1'b0, 3'd5);

    // Reset in the middle of a scan slot.
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_com",   {4'h0, com_h}, 8'h0F);
    chk("mrst_data",  data_h, 8'hFF);
    chk("mrst_tick",  {7'h0, tick_h}, 8'h00);
    chk("mrst_comn",  {4'h0, com_n}, 8'h0F);
    reset = 1'b0;
    count_to_tick("mrst");
    push_frame(16'h90EF, 4'b0001, 4'h0, 1'b0, 3'd5);
    check_frame("mrst_frm", 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
